// File: rtl/alu_exec_unit.sv
// Integer execute stage: single-cycle ALU ops plus a bit-serial shifter,
// delivering one registered result at a time over valid/ready handshakes.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] KIND_SLL = 2'd0;
    localparam logic [1:0] KIND_SRL = 2'd1;
    localparam logic [1:0] KIND_SRA = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [1:0]      kind_q, kind_d;

    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            is_shift;
    logic [1:0]      new_kind;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [XLEN-1:0] work_step;

    assign shamt     = op_b[SHW-1:0];
    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_SHIFT);
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_illegal = ill_q;

    // Single-cycle datapath; a zero-distance shift degenerates to op_a.
    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        new_kind = KIND_SLL;
        case (alu_control)
            4'b0000: alu_res = op_a + op_b;
            4'b0001: alu_res = op_a - op_b;
            4'b0010: alu_res = op_a & op_b;
            4'b0011: alu_res = op_a | op_b;
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                new_kind = KIND_SLL;
            end
            4'b0110: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                new_kind = KIND_SRL;
            end
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b1001: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                new_kind = KIND_SRA;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        case (kind_q)
            KIND_SRL: work_step = {1'b0, work_q[XLEN-1:1]};
            KIND_SRA: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default:  work_step = {work_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        case (state_q)
            S_SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_d = S_DONE;
                    res_d   = work_step;
                    zero_d  = (work_step == '0);
                    ill_d   = 1'b0;
                end
            end
            default: begin
                if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
                // A new op can load on the same edge the old result hands off.
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = S_SHIFT;
                        work_d  = op_a;
                        cnt_d   = shamt;
                        kind_d  = new_kind;
                    end else begin
                        state_d = S_DONE;
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        ill_d   = alu_ill;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
            kind_q  <= KIND_SLL;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a latency/queue reference model.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: one outstanding result, visible from cycle m_vat on
    bit          m_pend = 1'b0;
    logic [31:0] m_res = '0;
    bit          m_zero = 1'b0;
    bit          m_ill = 1'b0;
    int          m_vat = 0;
    int          m_cyc = 0;

    logic        s_valid, s_busy, s_ready, s_zero, s_ill, s_acc;
    logic [31:0] s_res;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b, output bit ill);
        logic [31:0] r;
        int s;
        s   = int'(b[4:0]);
        ill = 1'b0;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << s;
            4'd6: r = a >> s;
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: r = (a < b) ? 32'd1 : 32'd0;
            4'd9: r = $signed(a) >>> s;
            default: begin
                r   = 32'd0;
                ill = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic model_step();
        bit ev, rdy, ill;
        int lat;
        ev  = m_pend && (m_cyc >= m_vat);
        rdy = !m_pend || (ev && out_ready);
        if (ev && out_ready) m_pend = 1'b0;
        if (in_valid && rdy) begin
            m_res  = ref_result(alu_control, op_a, op_b, ill);
            m_ill  = ill;
            m_zero = (m_res == 32'd0);
            lat = 1;
            if ((alu_control == 4'd5 || alu_control == 4'd6 || alu_control == 4'd9) && op_b[4:0] != 5'd0)
                lat = int'(op_b[4:0]) + 1;
            m_vat  = m_cyc + lat;
            m_pend = 1'b1;
        end
        m_cyc++;
    endtask

    task automatic compare();
        bit ev;
        ev = m_pend && (m_cyc >= m_vat);
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("busy", {31'd0, busy}, {31'd0, m_pend && !ev});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pend || (ev && out_ready)});
        if (ev) begin
            chk("out_result", out_result, m_res);
            chk("out_zero", {31'd0, out_zero}, {31'd0, m_zero});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_valid = out_valid;
        s_busy  = busy;
        s_ready = in_ready;
        s_res   = out_result;
        s_zero  = out_zero;
        s_ill   = out_illegal;
        s_acc   = in_valid & in_ready;
        if (rst_n) compare();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        alu_control = c;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!s_acc && n < 100);
        chk("accept", {31'd0, s_acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic [31:0] exp, input int lat,
                               input int nbusy, input logic exp_ill);
        int n, nb;
        n = 0;
        nb = 0;
        do begin
            tick();
            n++;
            if (s_busy) nb++;
        end while (!s_valid && n < 100);
        chk({nm, "_valid"}, {31'd0, s_valid}, 32'd1);
        chk({nm, "_result"}, s_res, exp);
        chk({nm, "_zero"}, {31'd0, s_zero}, {31'd0, exp == 32'd0});
        chk({nm, "_illegal"}, {31'd0, s_ill}, {31'd0, exp_ill});
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_busy_cycles"}, nb, nbusy);
        $display("op %s: result=%h latency=%0d busy=%0d", nm, s_res, n, nb);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_zero", {31'd0, out_zero}, 32'd0);
        chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        send(4'd0, 32'h7FFFFFFF, 32'd1);
        wait_result("add_wrap", 32'h80000000, 1, 0, 1'b0);

        // SUB then SLT back-to-back
        send(4'd1, 32'd5, 32'd5);
        alu_control = 4'd7;
        op_a = 32'hFFFFFFFF;
        op_b = 32'd1;
        in_valid = 1'b1;
        tick();
        chk("b2b_sub_valid", {31'd0, s_valid}, 32'd1);
        chk("b2b_sub_result", s_res, 32'd0);
        chk("b2b_sub_zero", {31'd0, s_zero}, 32'd1);
        chk("b2b_accept", {31'd0, s_acc}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("b2b_slt_valid", {31'd0, s_valid}, 32'd1);
        chk("b2b_slt_result", s_res, 32'd1);
        $display("op b2b sub/slt: slt result=%h", s_res);
        send(4'd8, 32'hFFFFFFFF, 32'd1);
        wait_result("sltu", 32'd0, 1, 0, 1'b0);

        send(4'd9, 32'h80000000, 32'hFFFFFFE4);
        wait_result("sra4", 32'hF8000000, 5, 4, 1'b0);
        send(4'd6, 32'h80000000, 32'hFFFFFFE4);
        wait_result("srl4", 32'h08000000, 5, 4, 1'b0);
        send(4'd5, 32'd1, 32'd31);
        wait_result("sll31", 32'h80000000, 32, 31, 1'b0);
        send(4'd5, 32'h1234, 32'h20);
        wait_result("sll0", 32'h1234, 1, 0, 1'b0);

        // backpressure
        out_ready = 1'b0;
        send(4'd0, 32'd3, 32'd4);
        wait_result("bp_add", 32'd7, 1, 0, 1'b0);
        alu_control = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_a = $urandom;
            op_b = $urandom;
            tick();
            chk("bp_hold_result", s_res, 32'd7);
            chk("bp_in_ready", {31'd0, s_ready}, 32'd0);
        end
        op_a = 32'd10;
        op_b = 32'd20;
        out_ready = 1'b1;
        tick();
        chk("bp_handoff_accept", {31'd0, s_acc}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_next_result", s_res, 32'd30);
        $display("op backpressure: held 7, then result=%h", s_res);

        send(4'b1100, 32'h12345678, 32'h9ABCDEF0);
        wait_result("illegal", 32'd0, 1, 0, 1'b1);

        // asynchronous reset in the middle of a shift
        send(4'd9, 32'h80000000, 32'd10);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        $display("op reset mid-shift: valid=%0b busy=%0b", out_valid, busy);
        m_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'd0, 32'd2, 32'd3);
        wait_result("add_after_rst", 32'd5, 1, 0, 1'b0);

        // randomized traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            alu_control = 4'($urandom_range(0, 15));
            op_a = $urandom;
            op_b = $urandom;
            if ($urandom_range(0, 7) == 0) op_b = op_b & 32'hFFFFFFE0;
            if ($urandom_range(0, 7) == 0) op_a = op_b;
            tick();
            if (s_acc) $display("rand txn %0d: ctrl=%0d accepted", i, alu_control);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle integer execute stage directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code plus two operands and returns a registered result over a valid/ready handshake. Arithmetic, logic and compare ops complete in one cycle. Shifts run serially, one bit per cycle, to keep the shifter small.

Parameters:
XLEN, 32, operand/result width; must be a power of two >= 8; shift amount width SHW = log2(XLEN) (local, derived)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request this cycle
alu_control  input  4  op code from ALU control decoder
op_a  input  XLEN  operand A (rs1)
op_b  input  XLEN  operand B (rs2 or immediate); shifts use op_b[SHW-1:0]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  XLEN  registered result
out_zero  output  1  out_result == 0
out_illegal  output  1  alu_control was not a defined code
busy  output  1  high in SHIFT state

Behaviour:
- Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT (signed), 1000 SLTU, 1001 SRA. Codes 1010-1111 are illegal.
- Reset (async, rst_n=0): state IDLE; out_valid=0, out_result=0, out_zero=0, out_illegal=0, busy=0; internal shift counter and operands cleared. Reset mid-shift abandons the op; no result is emitted.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and never depends on in_valid.
- Accept = in_valid & in_ready.
  - Non-shift op, or shift with shamt=0: result computed combinationally and registered. Next state is DONE. Latency is 1 cycle (out_valid high the cycle after accept).
  - Shift op with shamt>0: latch op_a into the working register, shamt into a down-counter, and the shift kind. Next state is SHIFT.
- SHIFT: each cycle, shift the working register by 1 (SLL: insert 0 at LSB; SRL: insert 0 at MSB; SRA: replicate MSB) and decrement the counter. When the counter reaches 1 on this step, go to DONE. Latency is shamt+1 cycles from accept to out_valid. Maximum is XLEN cycles (shamt = XLEN-1). in_ready=0 and busy=1 throughout. in_valid is ignored.
- DONE: out_valid=1. out_result, out_zero and out_illegal are held stable until out_valid & out_ready.
  - out_ready=1 and accept: back-to-back. The new op is loaded in the same edge. Next state is DONE (1-cycle op) or SHIFT. out_valid stays 1 only for a 1-cycle op; for a shift it drops to 0.
  - out_ready=1 and no accept: next state IDLE, out_valid=0.
  - out_ready=0: hold.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN with no overflow flag. SLT/SLTU produce 1 or 0 zero-extended to XLEN. Shift amount uses only op_b[SHW-1:0]; upper bits are ignored.
- Illegal code: result=0, out_zero=1, out_illegal=1, 1-cycle latency. The unit is not blocked.
- out_zero is registered together with out_result and is never computed from stale data.
- Operand inputs are sampled only on accept. Later changes have no effect.

Test Plan:
- Reset, then ADD op_a=32'h7FFFFFFF, op_b=1, out_ready=1 -> one cycle later out_valid=1, out_result=32'h80000000, out_zero=0.
- SUB 5-5 then SLT op_a=32'hFFFFFFFF (-1), op_b=1 back-to-back with out_ready=1 -> consecutive cycles: result 0 with out_zero=1, then result 1. SLTU with the same operands -> 0.
- SRA op_a=32'h80000000, op_b=32'hFFFFFFE4 (shamt 4) -> busy high 4 cycles, in_ready low, out_valid on cycle 5 with result 32'hF8000000. SRL with the same inputs -> 32'h08000000. SLL by 31 of 1 -> 32'h80000000 after 32 cycles.
- Shamt 0 SLL of 32'h1234 -> 1-cycle latency, result 32'h1234, busy never asserted.
- Backpressure: result present with out_ready=0 for 5 cycles while in_valid=1 with changing operands -> result stable, in_ready=0, no new accept. Raise out_ready -> handoff plus accept in the same cycle.
- alu_control=4'b1100 -> out_illegal=1, result 0. Assert rst_n=0 mid-SRA (after 2 of 10 shift cycles) -> immediately out_valid=0, busy=0. After release, an ADD completes normally.
